// File: rtl/csr_ctrl.sv
// Serialises Zicsr instruction accesses and the mepc/mcause/mtvec trap-entry sequence onto one CSR port.
// Insn: accept -> INSN -> DONE (3-cycle issue rate); trap: 3 cycles to ack; trap wins in IDLE, no preemption.
module csr_ctrl #(
  parameter logic [11:0] ADR_MEPC   = 12'h341,
  parameter logic [11:0] ADR_MCAUSE = 12'h342,
  parameter logic [11:0] ADR_MTVEC  = 12'h305
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_insn_valid,
  output logic        o_insn_ready,
  input  logic [2:0]  i_insn_funct3,
  input  logic [11:0] i_insn_adr,
  input  logic [31:0] i_insn_src,
  input  logic [4:0]  i_insn_zimm,
  input  logic        i_insn_rs1_zero,
  input  logic        i_insn_rd_zero,
  output logic        o_insn_done,
  output logic [31:0] o_insn_rdata,
  output logic        o_insn_illegal,
  input  logic        i_trap_valid,
  input  logic [31:0] i_trap_pc,
  input  logic [31:0] i_trap_cause,
  output logic        o_trap_ack,
  output logic [31:0] o_trap_vec,
  output logic        o_csr_rd,
  output logic        o_csr_wr,
  output logic        o_csr_set,
  output logic        o_csr_clr,
  output logic [11:0] o_csr_adr,
  output logic [31:0] o_csr_wr_data,
  input  logic [31:0] i_csr_rd_data
);

  typedef enum logic [2:0] {
    IDLE,
    INSN,
    TRAP_EPC,
    TRAP_CAUSE,
    TRAP_VEC,
    DONE
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  f3_q;
  logic [11:0] adr_q;
  logic [31:0] opnd_q;
  logic        rs1_zero_q;
  logic        rd_zero_q;
  logic [31:0] rdata_q;
  logic [31:0] vec_q;
  logic        illegal;

  assign illegal = (f3_q[1:0] == 2'b00);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      f3_q       <= '0;
      adr_q      <= '0;
      opnd_q     <= '0;
      rs1_zero_q <= 1'b0;
      rd_zero_q  <= 1'b0;
      rdata_q    <= '0;
      vec_q      <= '0;
    end else begin
      state <= state_nxt;
      if (o_insn_ready) begin
        f3_q       <= i_insn_funct3;
        adr_q      <= i_insn_adr;
        opnd_q     <= i_insn_funct3[2] ? {27'b0, i_insn_zimm} : i_insn_src;
        rs1_zero_q <= i_insn_rs1_zero;
        rd_zero_q  <= i_insn_rd_zero;
      end
      // Old CSR value is sampled in the same cycle the write strobe is issued.
      if (state == INSN) rdata_q <= illegal ? 32'h0 : i_csr_rd_data;
      if (state == TRAP_VEC) vec_q <= i_csr_rd_data;
    end
  end

  // Vector is forwarded during the ack cycle, then held from the capture register.
  assign o_trap_vec   = (state == TRAP_VEC) ? i_csr_rd_data : vec_q;
  assign o_insn_rdata = rdata_q;

  always_comb begin
    state_nxt      = state;
    o_insn_ready   = 1'b0;
    o_insn_done    = 1'b0;
    o_insn_illegal = 1'b0;
    o_trap_ack     = 1'b0;
    o_csr_rd       = 1'b0;
    o_csr_wr       = 1'b0;
    o_csr_set      = 1'b0;
    o_csr_clr      = 1'b0;
    o_csr_adr      = '0;
    o_csr_wr_data  = '0;
    case (state)
      IDLE: begin
        if (i_trap_valid) begin
          state_nxt = TRAP_EPC;
        end else if (i_insn_valid) begin
          o_insn_ready = ~i_rst;
          state_nxt    = INSN;
        end
      end
      INSN: begin
        o_csr_adr     = adr_q;
        o_csr_wr_data = opnd_q;
        case (f3_q)
          3'b001, 3'b101: begin
            o_csr_wr = 1'b1;
            o_csr_rd = ~rd_zero_q;
          end
          3'b010, 3'b110: begin
            o_csr_rd  = 1'b1;
            o_csr_set = ~rs1_zero_q;
          end
          3'b011, 3'b111: begin
            o_csr_rd  = 1'b1;
            o_csr_clr = ~rs1_zero_q;
          end
          default: ;
        endcase
        state_nxt = DONE;
      end
      DONE: begin
        o_insn_done    = 1'b1;
        o_insn_illegal = illegal;
        state_nxt      = IDLE;
      end
      TRAP_EPC: begin
        o_csr_wr      = 1'b1;
        o_csr_adr     = ADR_MEPC;
        o_csr_wr_data = {i_trap_pc[31:1], 1'b0};
        state_nxt     = TRAP_CAUSE;
      end
      TRAP_CAUSE: begin
        o_csr_wr      = 1'b1;
        o_csr_adr     = ADR_MCAUSE;
        o_csr_wr_data = i_trap_cause;
        state_nxt     = TRAP_VEC;
      end
      TRAP_VEC: begin
        o_csr_rd   = 1'b1;
        o_csr_adr  = ADR_MTVEC;
        o_trap_ack = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/csr_ctrl.md
Name: csr_ctrl

Overview:
- Sequencer and arbiter in front of the single-port CSR unit.
- Accepts Zicsr instruction requests from the execute stage and trap-entry requests from the exception logic, and serialises them onto the one CSR access port.
- Decodes funct3 into rd/wr/set/clr strobes.
- Performs the three-access trap-entry sequence: write mepc, write mcause, read mtvec.

Parameters:
- ADR_MEPC, 12'h341, CSR address written with trap PC
- ADR_MCAUSE, 12'h342, CSR address written with trap cause
- ADR_MTVEC, 12'h305, CSR address read for trap vector

Ports:
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  asynchronous active-high reset
- i_insn_valid  in  1  instruction request valid
- o_insn_ready  out  1  request accepted this cycle
- i_insn_funct3  in  3  Zicsr funct3 (001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI)
- i_insn_adr  in  12  CSR address
- i_insn_src  in  32  rs1 value (register forms)
- i_insn_zimm  in  5  immediate (I forms)
- i_insn_rs1_zero  in  1  rs1 field (or zimm) is x0/0
- i_insn_rd_zero  in  1  rd field is x0
- o_insn_done  out  1  one-cycle pulse: result valid
- o_insn_rdata  out  32  old CSR value, held until next done
- o_insn_illegal  out  1  one-cycle pulse with done for funct3 000/100
- i_trap_valid  in  1  trap entry request (level, held until ack)
- i_trap_pc  in  32  faulting PC
- i_trap_cause  in  32  mcause value
- o_trap_ack  out  1  one-cycle pulse: sequence complete
- o_trap_vec  out  32  mtvec value captured, held until next ack
- o_csr_rd  out  1  CSR read strobe
- o_csr_wr  out  1  CSR write strobe
- o_csr_set  out  1  CSR set strobe
- o_csr_clr  out  1  CSR clear strobe
- o_csr_adr  out  12  CSR address
- o_csr_wr_data  out  32  CSR write/mask data
- i_csr_rd_data  in  32  CSR combinational read data

Behaviour:
- Reset (async, i_rst high): state IDLE. All outputs 0, including captured rdata/vec registers. Reset mid-sequence abandons it; no further strobes.
- States: IDLE, INSN, TRAP_EPC, TRAP_CAUSE, TRAP_VEC, DONE.
- IDLE:
  - i_trap_valid has priority: go to TRAP_EPC, o_insn_ready stays 0.
  - Otherwise, if i_insn_valid: o_insn_ready=1 (combinational in IDLE only), latch funct3/adr/operand, go to INSN.
  - Operand: I forms use {27'b0, zimm}; register forms use src.
- INSN (one cycle): drive o_csr_adr = latched adr, o_csr_wr_data = operand, and strobes per decode:
  - RW/RWI: wr=1; rd=~rd_zero.
  - RS/RSI: rd=1; set=~rs1_zero.
  - RC/RCI: rd=1; clr=~rs1_zero.
  - Illegal funct3: all strobes 0.
  - Capture i_csr_rd_data into o_insn_rdata (the value before the write lands). Go to DONE.
- DONE: o_insn_done=1 for one cycle; o_insn_illegal=1 if latched funct3 illegal, in which case rdata is 0. Return to IDLE. Back-to-back requests therefore issue every 3 cycles.
- TRAP_EPC: wr=1, adr=ADR_MEPC, data=i_trap_pc with bit0 cleared.
- TRAP_CAUSE: wr=1, adr=ADR_MCAUSE, data=i_trap_cause.
- TRAP_VEC: rd=1, adr=ADR_MTVEC; capture i_csr_rd_data into o_trap_vec; o_trap_ack=1 this cycle; return to IDLE.
- Trap latency: 3 cycles after leaving IDLE.
- i_trap_pc and i_trap_cause must stay stable until ack; the block does not latch them.
- Simultaneous trap and insn in IDLE: trap wins; insn stays pending (not acknowledged) and is served after ack if still valid.
- A trap arriving while an insn is in INSN/DONE waits; no preemption.
- Exactly one access strobe family is active per cycle; in IDLE/DONE all strobes are 0 and o_csr_adr/o_csr_wr_data are 0.

Test Plan:
- Reset mid-trap: assert i_rst during TRAP_CAUSE -> all outputs 0 immediately; next cycle after release no strobes; the previously written mepc value stays.
- CSRRW adr 0x200 src 0xDEADBEEF, rd_zero=0, CSR previously 0x12 -> INSN cycle wr=1 rd=1 adr=0x200; done pulse with rdata 0x12; subsequent CSRRS src 0 (rs1_zero=1) returns 0xDEADBEEF with set=0.
- CSRRCI adr 0x800 zimm 5, CSR value 0xF -> clr=1 data=0x5; rdata 0xF; CSR becomes 0xA. Same with zimm=0/rs1_zero=1 -> clr=0, value unchanged.
- Trap pc=0x1003 cause=0x8000000B, mtvec=0x100 -> three cycles: wr 0x341/0x1002, wr 0x342/0x8000000B, rd 0x305; ack pulse with trap_vec 0x100.
- Trap and insn valid in the same cycle -> ready=0 until trap ack; insn accepted the cycle after returning to IDLE, done 2 cycles later.
- funct3=100 -> no strobes in INSN; done and illegal pulse together; rdata 0.
